// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: datapath width, reset PC, NOP word,
// PC increment and the stage boot/run FSM encoding.
package pipeline_pkg;

   localparam int XLEN = 32;
   localparam int PC_INC = 4;

   localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      BOOT = 1'b0,
      RUN  = 1'b1
   } stage_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts cycles with inc_i=1, sticks at all-ones.
// Ports: clk_i, rst_i (async high), inc_i, count_o[CNT_W].
module sat_counter #(
   parameter int CNT_W = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             inc_i,
   output logic [CNT_W-1:0] count_o
);

   logic full;

   assign full = &count_o;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         count_o <= '0;
      end else if (inc_i && !full) begin
         count_o <= count_o + CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC register, imem address, IF/ID register, boot FSM and
// fetch/stall/flush counters. Ports follow the pipeline control bundle.
module fetch_stage
   import pipeline_pkg::*;
#(
   parameter int                    XLEN      = pipeline_pkg::XLEN,
   parameter logic [XLEN-1:0]       RESET_PC  = pipeline_pkg::RESET_PC,
   parameter logic [31:0]           NOP_INSTR = pipeline_pkg::NOP_INSTR,
   parameter int                    CNT_W     = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             pc_write_i,
   input  logic             stall_i,
   input  logic             flush_i,
   input  logic [XLEN-1:0]  branch_target_i,
   input  logic [31:0]      imem_data_i,
   output logic [XLEN-1:0]  imem_addr_o,
   output logic [XLEN-1:0]  if_id_pc_o,
   output logic [31:0]      if_id_instr_o,
   output logic             if_id_valid_o,
   output logic             misalign_o,
   output logic [CNT_W-1:0] fetch_cnt_o,
   output logic [CNT_W-1:0] stall_cnt_o,
   output logic [CNT_W-1:0] flush_cnt_o
);

   stage_e state;
   stage_e state_nxt;

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_nxt;
   logic [XLEN-1:0] pc_seq;
   logic [XLEN-1:0] ipc_nxt;
   logic [31:0]     instr_nxt;
   logic            valid_nxt;
   logic            mis_nxt;
   logic            fetch_inc;
   logic            stall_inc;
   logic            flush_inc;

   assign pc_seq      = pc + XLEN'(PC_INC);
   assign imem_addr_o = pc;

   always_comb begin
      state_nxt = RUN;
      pc_nxt    = pc;
      ipc_nxt   = if_id_pc_o;
      instr_nxt = if_id_instr_o;
      valid_nxt = if_id_valid_o;
      mis_nxt   = misalign_o;
      fetch_inc = 1'b0;
      stall_inc = 1'b0;
      flush_inc = 1'b0;
      unique case (state)
         BOOT: begin
            // First cycle after reset: fetch unconditionally.
            pc_nxt    = pc_seq;
            ipc_nxt   = pc;
            instr_nxt = imem_data_i;
            valid_nxt = 1'b1;
            fetch_inc = 1'b1;
         end
         RUN: begin
            if (stall_i) begin
               // IF/ID frozen; a flush here is re-resolved later.
               stall_inc = 1'b1;
               if (pc_write_i) begin
                  pc_nxt = pc_seq;
               end
            end else if (flush_i && pc_write_i) begin
               pc_nxt    = {branch_target_i[XLEN-1:2], 2'b00};
               ipc_nxt   = pc;
               instr_nxt = NOP_INSTR;
               valid_nxt = 1'b0;
               mis_nxt   = misalign_o | (|branch_target_i[1:0]);
               flush_inc = 1'b1;
            end else begin
               if (pc_write_i) begin
                  pc_nxt = pc_seq;
               end
               ipc_nxt   = pc;
               instr_nxt = imem_data_i;
               valid_nxt = 1'b1;
               fetch_inc = 1'b1;
            end
         end
         default: begin
            state_nxt = RUN;
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state         <= BOOT;
         pc            <= RESET_PC;
         if_id_pc_o    <= '0;
         if_id_instr_o <= NOP_INSTR;
         if_id_valid_o <= 1'b0;
         misalign_o    <= 1'b0;
      end else begin
         state         <= state_nxt;
         pc            <= pc_nxt;
         if_id_pc_o    <= ipc_nxt;
         if_id_instr_o <= instr_nxt;
         if_id_valid_o <= valid_nxt;
         misalign_o    <= mis_nxt;
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_fetch_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (fetch_inc),
      .count_o(fetch_cnt_o)
   );

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_stall_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (stall_inc),
      .count_o(stall_cnt_o)
   );

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_flush_cnt (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .inc_i  (flush_inc),
      .count_o(flush_cnt_o)
   );

endmodule
